hvsync_generator: RTL and testbench

HVSYNC_GENERATOR -- requirements
Module: hvsync_generator

---
 rtl/hvsync_generator.sv | 84 ++++++++
 tb/tb_hvsync_generator.sv | 130 +++++++++++++
 2 files changed

// File: rtl/hvsync_generator.sv
// Free-running horizontal/vertical beam counters with registered sync pulses.
// Define HVSYNC_SYNC_INVERT_EN for active-low hsync/vsync (idle high).
module hvsync_generator #(
  parameter int H_DISPLAY = 256,
  parameter int H_BACK    = 23,
  parameter int H_FRONT   = 7,
  parameter int H_SYNC    = 23,
  parameter int V_DISPLAY = 240,
  parameter int V_TOP     = 5,
  parameter int V_BOTTOM  = 14,
  parameter int V_SYNC    = 3
) (
  input  logic       clk,
  input  logic       reset,
  output logic       hsync,
  output logic       vsync,
  output logic       display_on,
  output logic [8:0] hpos,
  output logic [8:0] vpos
);

  localparam logic [8:0] H_DISP_C       = 9'(H_DISPLAY);
  localparam logic [8:0] H_SYNC_START_C = 9'(H_DISPLAY + H_FRONT);
  localparam logic [8:0] H_SYNC_END_C   = 9'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [8:0] H_MAX_C        = 9'(H_DISPLAY + H_BACK + H_FRONT + H_SYNC - 1);

  localparam logic [8:0] V_DISP_C       = 9'(V_DISPLAY);
  localparam logic [8:0] V_SYNC_START_C = 9'(V_DISPLAY + V_BOTTOM);
  localparam logic [8:0] V_SYNC_END_C   = 9'(V_DISPLAY + V_BOTTOM + V_SYNC - 1);
  localparam logic [8:0] V_MAX_C        = 9'(V_DISPLAY + V_TOP + V_BOTTOM + V_SYNC - 1);

`ifdef HVSYNC_SYNC_INVERT_EN
  localparam logic SYNC_ON = 1'b0;
`else
  localparam logic SYNC_ON = 1'b1;
`endif

  logic h_wrap;
  logic v_wrap;
  logic h_in_sync;
  logic v_in_sync;

  assign h_wrap    = (hpos == H_MAX_C);
  assign v_wrap    = (vpos == V_MAX_C);
  assign h_in_sync = (hpos >= H_SYNC_START_C) && (hpos <= H_SYNC_END_C);
  assign v_in_sync = (vpos >= V_SYNC_START_C) && (vpos <= V_SYNC_END_C);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hpos <= '0;
    end else if (h_wrap) begin
      hpos <= '0;
    end else begin
      hpos <= hpos + 9'd1;
    end
  end

  // The line counter only moves on the clock where the pixel counter wraps.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vpos <= '0;
    end else if (h_wrap) begin
      if (v_wrap) begin
        vpos <= '0;
      end else begin
        vpos <= vpos + 9'd1;
      end
    end
  end

  // Sync outputs lag the counters by one clock since they sample the current position.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hsync <= ~SYNC_ON;
      vsync <= ~SYNC_ON;
    end else begin
      hsync <= h_in_sync ? SYNC_ON : ~SYNC_ON;
      vsync <= v_in_sync ? SYNC_ON : ~SYNC_ON;
    end
  end

  assign display_on = (hpos < H_DISP_C) && (vpos < V_DISP_C);

endmodule

// File: tb/tb_hvsync_generator.sv
// Scoreboard bench for hvsync_generator: expected beam state derived from the
// number of clocks since reset release, checked by a negedge monitor.
module tb_hvsync_generator;

  localparam int H_TOTAL = 309;
  localparam int V_TOTAL = 262;
  localparam int FRAME   = H_TOTAL * V_TOTAL;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       de;
    logic [8:0] h;
    logic [8:0] v;
  } exp_t;

  logic       clk;
  logic       reset;
  logic       hsync;
  logic       vsync;
  logic       display_on;
  logic [8:0] hpos;
  logic [8:0] vpos;

  exp_t exp_q[$];
  int   total;
  int   bad;
  int   n;

  hvsync_generator dut (
    .clk       (clk),
    .reset     (reset),
    .hsync     (hsync),
    .vsync     (vsync),
    .display_on(display_on),
    .hpos      (hpos),
    .vpos      (vpos)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Beam position after cyc clocks of free running; syncs follow the previous position.
  function automatic exp_t model(input int cyc);
    exp_t e;
    int h, v, hp, vp;
    h    = cyc % H_TOTAL;
    v    = (cyc / H_TOTAL) % V_TOTAL;
    e.h  = 9'(h);
    e.v  = 9'(v);
    e.de = (h < 256) && (v < 240);
    e.hs = 1'b0;
    e.vs = 1'b0;
    if (cyc > 0) begin
      hp   = (cyc - 1) % H_TOTAL;
      vp   = ((cyc - 1) / H_TOTAL) % V_TOTAL;
      e.hs = (hp >= 263) && (hp <= 285);
      e.vs = (vp >= 254) && (vp <= 256);
    end
`ifdef HVSYNC_SYNC_INVERT_EN
    e.hs = ~e.hs;
    e.vs = ~e.vs;
`endif
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [8:0] act, input logic [8:0] req);
    total++;
    if (act !== req) begin
      bad++;
      if (bad <= 40)
        $display("[TB] FAIL %s at t=%0t n=%0d: got %0d expected %0d", name, $time, n, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) n++;
    #2;
  endtask

  task automatic applyStimulus(input int cycles, input logic rst_val);
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (reset !== rst_val) begin
        reset = rst_val;
        if (!rst_val) n = 0;
      end
      exp_q.push_back(model(n));
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checkOutput("hpos",       hpos,               e.h);
      checkOutput("vpos",       vpos,               e.v);
      checkOutput("hsync",      {8'd0, hsync},      {8'd0, e.hs});
      checkOutput("vsync",      {8'd0, vsync},      {8'd0, e.vs});
      checkOutput("display_on", {8'd0, display_on}, {8'd0, e.de});
    end
  end

  initial begin
    total = 0;
    bad   = 0;
    n     = 0;
    reset = 1'b0;

    applyStimulus(3, 1'b0);

    // Random bursts of running interrupted by asynchronous mid-line resets.
    for (int seg = 0; seg < 8; seg++) begin
      applyStimulus(int'($urandom_range(1, 400)), 1'b1);
      applyStimulus(int'($urandom_range(1, 4)), 1'b0);
    end

    // One full frame plus a couple of clocks to see the wrap back to (0,0).
    applyStimulus(FRAME + 3, 1'b1);

    @(negedge clk);
    #1;
    checkOutput("drain", 9'(exp_q.size()), 9'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
